// File: rtl/sm_bus_arbiter_if.sv
// Two-master request/ack ports plus the single shared bus toward the bus matrix.
// Handshake: mXReq is held high with address/write/data stable until a one-cycle mXAck; mXRData is valid in that Ack cycle.
interface sm_bus_arbiter_if;
    logic        m0Req;
    logic [31:0] m0Addr;
    logic        m0Write;
    logic [31:0] m0WData;
    logic [31:0] m0RData;
    logic        m0Ack;

    logic        m1Req;
    logic [31:0] m1Addr;
    logic        m1Write;
    logic [31:0] m1WData;
    logic [31:0] m1RData;
    logic        m1Ack;

    logic [31:0] bAddr;
    logic        bWrite;
    logic [31:0] bWData;
    logic [31:0] bRData;

    // Arbiter side: accepts master requests, drives the shared bus.
    modport slave (
        input  m0Req, m0Addr, m0Write, m0WData,
        input  m1Req, m1Addr, m1Write, m1WData,
        input  bRData,
        output m0RData, m0Ack, m1RData, m1Ack,
        output bAddr, bWrite, bWData
    );

    // Environment side: masters plus the bus matrix model.
    modport master (
        output m0Req, m0Addr, m0Write, m0WData,
        output m1Req, m1Addr, m1Write, m1WData,
        output bRData,
        input  m0RData, m0Ack, m1RData, m1Ack,
        input  bAddr, bWrite, bWData
    );
endinterface

// File: rtl/sm_bus_arbiter.sv
// Two-master bus arbiter: IDLE -> ACCESS (one bus cycle) -> DONE (Ack cycle).
// Round-robin or fixed-priority tie-break; per-master captured read data.
module sm_bus_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    sm_bus_arbiter_if.slave   bus,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        winner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        winner       = 1'b0;
        bus.bAddr    = '0;
        bus.bWrite   = 1'b0;
        bus.bWData   = '0;
        bus.m0Ack    = 1'b0;
        bus.m1Ack    = 1'b0;

        // A lone requester wins outright; on a tie the tie-break decides.
        if (bus.m0Req && bus.m1Req) begin
            if (FIXED_PRIO) winner = 1'b0;
            else            winner = ~last_grant_q;
        end else begin
            winner = bus.m1Req;
        end

        case (state_q)
            IDLE: begin
                if (bus.m0Req || bus.m1Req) begin
                    grant_d      = winner;
                    last_grant_d = winner;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (grant_q) begin
                    bus.bAddr  = bus.m1Addr;
                    bus.bWrite = bus.m1Write;
                    bus.bWData = bus.m1WData;
                    rdata1_d   = bus.bRData;
                end else begin
                    bus.bAddr  = bus.m0Addr;
                    bus.bWrite = bus.m0Write;
                    bus.bWData = bus.m0WData;
                    rdata0_d   = bus.bRData;
                end
                state_d = DONE;
            end
            DONE: begin
                bus.m0Ack = ~grant_q;
                bus.m1Ack = grant_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.m0RData = rdata0_q;
    assign bus.m1RData = rdata1_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_sm_bus_arbiter.sv
// Directed bench for sm_bus_arbiter: one round-robin instance and one fixed-priority instance.
module tb_sm_bus_arbiter;
    logic       clk;
    logic       rst_n;
    logic [1:0] st0;
    logic [1:0] st1;
    int         total;
    int         bad;

    sm_bus_arbiter_if bi0 ();
    sm_bus_arbiter_if bi1 ();

    sm_bus_arbiter #(.FIXED_PRIO(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bi0), .dbg_state(st0));
    sm_bus_arbiter #(.FIXED_PRIO(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bi1), .dbg_state(st1));

    // Bus matrix model: combinational read data from the address.
    function automatic logic [31:0] bus_model(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'hCAFE_BABE;
        return a ^ 32'h5A5A_0000;
    endfunction

    assign bi0.bRData = bus_model(bi0.bAddr);
    assign bi1.bRData = bus_model(bi1.bAddr);

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bi0.m0Req = 1'b0; bi0.m0Addr = '0; bi0.m0Write = 1'b0; bi0.m0WData = '0;
        bi0.m1Req = 1'b0; bi0.m1Addr = '0; bi0.m1Write = 1'b0; bi0.m1WData = '0;
        bi1.m0Req = 1'b0; bi1.m0Addr = '0; bi1.m0Write = 1'b0; bi1.m0WData = '0;
        bi1.m1Req = 1'b0; bi1.m1Addr = '0; bi1.m1Write = 1'b0; bi1.m1WData = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #3;
        total++; if (st0 !== 2'd0 || st1 !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d/%0d want 0/0", st0, st1); end
        total++; if (bi0.m0Ack !== 1'b0 || bi0.m1Ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %0b%0b want 00", bi0.m0Ack, bi0.m1Ack); end
        total++; if (bi0.m0RData !== 32'h0 || bi0.m1RData !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h/%h want 0/0", bi0.m0RData, bi0.m1RData); end
        total++; if (bi0.bAddr !== 32'h0 || bi0.bWData !== 32'h0 || bi0.bWrite !== 1'b0) begin bad++; $display("FAIL reset_bus: got %h/%h/%0b want 0/0/0", bi0.bAddr, bi0.bWData, bi0.bWrite); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        bi0.m0Req = 1'b1; bi0.m0Addr = 32'h0000_0010; bi0.m0Write = 1'b0;
        total++; if (st0 !== 2'd0) begin bad++; $display("FAIL read_idle: got %0d want 0", st0); end
        @(negedge clk);
        total++; if (st0 !== 2'd1) begin bad++; $display("FAIL read_access_state: got %0d want 1", st0); end
        total++; if (bi0.bAddr !== 32'h10 || bi0.bWrite !== 1'b0) begin bad++; $display("FAIL read_bus: got %h/%0b want 10/0", bi0.bAddr, bi0.bWrite); end
        total++; if (bi0.m0Ack !== 1'b0) begin bad++; $display("FAIL read_early_ack: got %0b want 0", bi0.m0Ack); end
        @(negedge clk);
        total++; if (bi0.m0Ack !== 1'b1 || bi0.m1Ack !== 1'b0) begin bad++; $display("FAIL read_ack: got %0b%0b want 10", bi0.m0Ack, bi0.m1Ack); end
        total++; if (bi0.m0RData !== 32'hCAFE_BABE) begin bad++; $display("FAIL read_data: got %h want cafebabe", bi0.m0RData); end
        total++; if (bi0.bAddr !== 32'h0) begin bad++; $display("FAIL read_bus_done: got %h want 0", bi0.bAddr); end
        bi0.m0Req = 1'b0;
        @(negedge clk);
        total++; if (bi0.m0Ack !== 1'b0 || st0 !== 2'd0) begin bad++; $display("FAIL read_after: got ack %0b state %0d want 0/0", bi0.m0Ack, st0); end
        total++; if (bi0.m0RData !== 32'hCAFE_BABE) begin bad++; $display("FAIL read_hold: got %h want cafebabe", bi0.m0RData); end
    endtask

    task automatic test_single_write();
        int wr_cycles;
        wr_cycles = 0;
        @(negedge clk);
        bi0.m1Req = 1'b1; bi0.m1Write = 1'b1; bi0.m1Addr = 32'h0000_7f00; bi0.m1WData = 32'h5;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            if (bi0.bWrite === 1'b1) begin
                wr_cycles++;
                total++; if (bi0.bAddr !== 32'h7f00 || bi0.bWData !== 32'h5) begin bad++; $display("FAIL write_bus: got %h/%h want 7f00/5", bi0.bAddr, bi0.bWData); end
            end
            if (k == 1) begin
                total++; if (bi0.bWrite !== 1'b1) begin bad++; $display("FAIL write_cycle: got %0b want 1", bi0.bWrite); end
            end
            if (k == 2) begin
                total++; if (bi0.m1Ack !== 1'b1 || bi0.m0Ack !== 1'b0) begin bad++; $display("FAIL write_ack: got %0b%0b want 01", bi0.m0Ack, bi0.m1Ack); end
                bi0.m1Req = 1'b0; bi0.m1Write = 1'b0;
            end else begin
                total++; if (bi0.m1Ack !== 1'b0) begin bad++; $display("FAIL write_stray_ack k=%0d: got %0b want 0", k, bi0.m1Ack); end
            end
        end
        total++; if (wr_cycles != 1) begin bad++; $display("FAIL write_count: got %0d want 1", wr_cycles); end
    endtask

    task automatic test_contention_rr();
        logic e0, e1;
        logic [31:0] ea;
        pulse_reset();
        bi0.m0Req = 1'b1; bi0.m0Addr = 32'h100;
        bi0.m1Req = 1'b1; bi0.m1Addr = 32'h200;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            e0 = (k % 3 == 2) && ((k / 3) % 2 == 0);
            e1 = (k % 3 == 2) && ((k / 3) % 2 == 1);
            total++; if (bi0.m0Ack !== e0 || bi0.m1Ack !== e1) begin bad++; $display("FAIL rr_ack k=%0d: got %0b%0b want %0b%0b", k, bi0.m0Ack, bi0.m1Ack, e0, e1); end
            if (k % 3 == 1) begin
                ea = ((k / 3) % 2 == 0) ? 32'h100 : 32'h200;
                total++; if (bi0.bAddr !== ea) begin bad++; $display("FAIL rr_addr k=%0d: got %h want %h", k, bi0.bAddr, ea); end
            end
        end
        bi0.m0Req = 1'b0; bi0.m1Req = 1'b0;
        total++; if (bi0.m0RData !== 32'h5A5A_0100 || bi0.m1RData !== 32'h5A5A_0200) begin bad++; $display("FAIL rr_rdata: got %h/%h want 5a5a0100/5a5a0200", bi0.m0RData, bi0.m1RData); end
    endtask

    task automatic test_fixed_prio();
        logic e0;
        int   m1_pulses;
        m1_pulses = 0;
        pulse_reset();
        bi1.m0Req = 1'b1; bi1.m0Addr = 32'h100;
        bi1.m1Req = 1'b1; bi1.m1Addr = 32'h200;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            e0 = (k % 3 == 2);
            if (bi1.m1Ack !== 1'b0) m1_pulses++;
            total++; if (bi1.m0Ack !== e0) begin bad++; $display("FAIL fp_ack k=%0d: got %0b want %0b", k, bi1.m0Ack, e0); end
            if (k % 3 == 1) begin
                total++; if (bi1.bAddr !== 32'h100) begin bad++; $display("FAIL fp_addr k=%0d: got %h want 100", k, bi1.bAddr); end
            end
        end
        bi1.m0Req = 1'b0; bi1.m1Req = 1'b0;
        total++; if (m1_pulses != 0) begin bad++; $display("FAIL fp_m1_ack: got %0d pulses want 0", m1_pulses); end
    endtask

    task automatic test_req_drop();
        @(negedge clk);
        bi0.m1Req = 1'b1; bi0.m1Addr = 32'h300; bi0.m1Write = 1'b0;
        @(negedge clk);
        total++; if (bi0.bAddr !== 32'h300) begin bad++; $display("FAIL drop_addr: got %h want 300", bi0.bAddr); end
        bi0.m1Req = 1'b0;
        @(negedge clk);
        total++; if (bi0.m1Ack !== 1'b1) begin bad++; $display("FAIL drop_ack: got %0b want 1", bi0.m1Ack); end
        total++; if (bi0.m1RData !== 32'h5A5A_0300) begin bad++; $display("FAIL drop_rdata: got %h want 5a5a0300", bi0.m1RData); end
    endtask

    task automatic test_withdrawn();
        int stray;
        stray = 0;
        @(negedge clk);
        bi0.m0Req = 1'b1; bi0.m0Addr = 32'h40; bi0.m0Write = 1'b0;
        @(negedge clk);
        bi0.m1Req = 1'b1; bi0.m1Addr = 32'h500;
        @(negedge clk);
        total++; if (bi0.m0Ack !== 1'b1 || bi0.m1Ack !== 1'b0) begin bad++; $display("FAIL wd_m0_ack: got %0b%0b want 10", bi0.m0Ack, bi0.m1Ack); end
        bi0.m1Req = 1'b0; bi0.m0Req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bi0.m1Ack !== 1'b0 || st0 !== 2'd0 || bi0.bAddr !== 32'h0) stray++;
        end
        total++; if (stray != 0) begin bad++; $display("FAIL wd_m1_cycle: got %0d stray cycles want 0", stray); end
    endtask

    task automatic test_reset_mid_access();
        int stray;
        stray = 0;
        @(negedge clk);
        bi0.m0Req = 1'b1; bi0.m0Write = 1'b1; bi0.m0Addr = 32'h80; bi0.m0WData = 32'h1234;
        @(negedge clk);
        total++; if (bi0.bWrite !== 1'b1) begin bad++; $display("FAIL rst_mid_pre: got %0b want 1", bi0.bWrite); end
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (bi0.bWrite !== 1'b0 || bi0.bAddr !== 32'h0 || bi0.bWData !== 32'h0) begin bad++; $display("FAIL rst_mid_bus: got %0b/%h/%h want 0/0/0", bi0.bWrite, bi0.bAddr, bi0.bWData); end
        total++; if (st0 !== 2'd0 || bi0.m0RData !== 32'h0 || bi0.m1RData !== 32'h0) begin bad++; $display("FAIL rst_mid_regs: got %0d/%h/%h want 0/0/0", st0, bi0.m0RData, bi0.m1RData); end
        bi0.m0Req = 1'b0; bi0.m0Write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bi0.m0Ack !== 1'b0 || st0 !== 2'd0) stray++;
        end
        total++; if (stray != 0) begin bad++; $display("FAIL rst_mid_ack: got %0d stray cycles want 0", stray); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_read();
        test_single_write();
        test_contention_rr();
        test_fixed_prio();
        test_req_drop();
        test_withdrawn();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sm_bus_arbiter.md
SM_BUS_ARBITER -- requirements
Module: sm_bus_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0, meaning: 0 = round-robin between masters; 1 = master 0 always wins a tie.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 m0Req  input  1  master 0 (CPU) request; held high with m0Addr/m0Write/m0WData stable until m0Ack.
REQ-005 m0Addr  input  32  master 0 address.
REQ-006 m0Write  input  1  master 0 write enable.
REQ-007 m0WData  input  32  master 0 write data.
REQ-008 m0RData  output  32  master 0 read data, valid in m0Ack cycle.
REQ-009 m0Ack  output  1  master 0 completion pulse, one cycle.
REQ-010 m1Req, m1Addr[32], m1Write, m1WData[32] inputs; m1RData[32], m1Ack outputs: master 1 (DMA/debug), same meanings as master 0.
REQ-011 bAddr  output  32  address to bus matrix.
REQ-012 bWrite  output  1  write enable to bus matrix.
REQ-013 bWData  output  32  write data to bus matrix.
REQ-014 bRData  input  32  read data from bus matrix, combinational from bAddr in the same cycle.

Function
REQ-015 FSM states IDLE, ACCESS, DONE; only these three, encoded in a registered state variable.
REQ-016 IDLE: no request -> stay IDLE; any request -> latch winner into grant register, go ACCESS.
REQ-017 Winner: only one requester -> that master; both, FIXED_PRIO=1 -> master 0; both, FIXED_PRIO=0 -> master not equal to lastGrant.
REQ-018 lastGrant updated to winner on IDLE->ACCESS transition only.
REQ-019 ACCESS (exactly one cycle): bAddr/bWrite/bWData = granted master's inputs; bRData captured into rdata register at end of cycle; go DONE.
REQ-020 Outside ACCESS: bAddr=0, bWrite=0, bWData=0; no bus write ever occurs outside ACCESS.
REQ-021 DONE (exactly one cycle): granted master's Ack=1, its RData = captured register; other master's Ack=0; go IDLE.
REQ-022 mXRData holds last captured value for the master that owns it; writes also capture bRData (value don't-care to master).
REQ-023 Latency: request seen in IDLE at cycle N -> bus access cycle N+1 -> Ack cycle N+2; minimum 3 cycles per transaction.
REQ-024 Requests arriving in ACCESS or DONE are not sampled; considered in next IDLE.
REQ-025 Master deasserting Req while not granted: dropped silently, no Ack.
REQ-026 Master deasserting Req during its ACCESS/DONE: transaction completes, Ack still pulsed (protocol violation, not masked).
REQ-027 Never both m0Ack and m1Ack high in the same cycle; at most one grant outstanding.
REQ-028 Round-robin guarantee: with both Req held continuously, grants alternate 0,1,0,1...; neither master waits more than one other transaction.

Reset
REQ-029 rst_n low -> immediately: state=IDLE, lastGrant=1 (master 0 wins first tie), grant=0, rdata registers=0, m0Ack=m1Ack=0, m0RData=m1RData=0, bAddr=bWData=0, bWrite=0.
REQ-030 Reset asserted mid-ACCESS aborts the transaction: bWrite drops asynchronously, no Ack issued after release.
REQ-031 After rst_n rises, first transition evaluated on the next rising clk edge.

Verification
REQ-032 Single read: m0Req=1, m0Addr=0x00000010, bRData model returns 0xCAFEBABE -> bAddr=0x10 in cycle N+1, m0Ack=1 with m0RData=0xCAFEBABE in N+2.
REQ-033 Single write: m1Req=1, m1Write=1, m1Addr=0x00007f00, m1WData=0x5 -> bWrite=1 for exactly one cycle with bAddr=0x7f00, bWData=0x5; m1Ack at N+2.
REQ-034 Contention, FIXED_PRIO=0: both Req held from reset for 4 transactions -> grant order 0,1,0,1; Ack pulses every 3 cycles, never simultaneous.
REQ-035 Contention, FIXED_PRIO=1: both Req held; master 0 re-requests in each IDLE -> master 0 always granted, m1Ack never pulses.
REQ-036 Reset mid-ACCESS: assert rst_n=0 during master 0 write cycle -> bWrite=0 same time-step, all outputs at reset values, no m0Ack after release.
REQ-037 Withdrawn request: m1Req high one cycle while master 0 in ACCESS, then low -> no bus cycle for master 1, m1Ack stays 0.
